char_renderer: RTL
==================

// Module: char_renderer
// PURPOSE
//  Text-mode pixel stage directly downstream of sync_generator, clocked by its px_clk.
//  - Input: hc/vc counters and sync/blank flags.
//  - Fetches the character code from the external screen buffer RAM, then the glyph row from the font ROM.
//  - Applies the inverse-video attribute and a blinking block cursor.
//  - Emits a 1-bit pixel plus hsync/vsync/blank, all delayed to the same 3-cycle latency.
//  - Display area: 64 cols x 16 rows of 8x16 glyphs (512x256).
// PARAMETERS
//  HBP        112  first visible hc (back porch)
//  VBP        145  first visible vc
//  COLS       64   text columns (log2 = 6)
//  ROWS       16   text rows (log2 = 4)
//  BLINK_LOG2 5    cursor blink period = 2^BLINK_LOG2 frames
//  SYNC_OFF   1'b1 inactive sync level driven at reset
// PORTS
//  px_clk      in   1   pixel clock (from sync_generator)
//  clr         in   1   asynchronous reset, active-high
//  hc          in   11  horizontal counter
//  vc          in   11  vertical counter
//  hsync       in   1   hsync aligned with hc/vc
//  vsync       in   1   vsync aligned with hc/vc
//  hblank      in   1   horizontal blank aligned with hc/vc
//  vblank      in   1   vertical blank aligned with hc/vc
//  cursor_x    in   6   cursor column
//  cursor_y    in   4   cursor row
//  cursor_en   in   1   cursor enable
//  buffer_addr out  10  {row[3:0], col[5:0]} to buffer RAM; synchronous read, 1-cycle latency
//  buffer_data in   8   [7] inverse attribute, [6:0] character code
//  font_addr   out  11  {code[6:0], line[3:0]} to font ROM; synchronous read, 1-cycle latency
//  font_data   in   8   glyph row; bit 7 = leftmost pixel
//  pixel       out  1   video out; 1 = lit
//  hsync_out   out  1   hsync delayed 3 cycles
//  vsync_out   out  1   vsync delayed 3 cycles
//  blank_out   out  1   (hblank|vblank) delayed 3 cycles
// BEHAVIOUR
//  Reset (async, immediate): pixel=0, hsync_out=vsync_out=SYNC_OFF, blank_out=1.
//   All pipeline registers reset to the blank state; frame_cnt=0.
//  Position math at cycle t:
//   x = hc-HBP, y = vc-VBP (11-bit, wrapping)
//   col = x[8:3], bit = x[2:0], row = y[7:4], line = y[3:0]
//  buffer_addr = {row,col}, combinational from hc/vc.
//   Always in range; value during blank is don't-care.
//  t+1: buffer_data valid. Register line, bit, blank, and cursor_hit = cursor_en && col==cursor_x && row==cursor_y.
//   font_addr = {buffer_data[6:0], line_d1}, combinational.
//  t+2: font_data valid. buffer_data[7] registered as inv_d2.
//  t+3: pixel <= blank_d2 ? 0 : font_data[7-bit_d2] ^ inv_d2 ^ (cursor_d2 & blink_on).
//   hsync_out, vsync_out and blank_out are registered on the same edge, so every output has exactly 3-cycle latency.
//  Blink:
//   frame_cnt (BLINK_LOG2 bits) increments on each cycle with hc==0 && vc==0 and wraps naturally.
//   blink_on = ~frame_cnt[BLINK_LOG2-1], so the cursor is visible in the first half period after reset.
//  Cursor and inverse on the same cell cancel (XOR); the cursor over an inverse cell shows normal video.
//  cursor_x/y/en are sampled per pixel. Changes mid-frame take effect at the next affected pixel, with no tearing guarantee.
//  No handshakes: one pixel per px_clk, no stall.
//  Reset released mid-line: the pipeline refills, and outputs are blank for the first 3 cycles, then valid.
// STRUCTURE
//  Shared header vt52_params.vh holds HBP, VBP, COLS, ROWS, glyph 8x16 and SYNC_OFF.
//   sync_generator uses the same header.
//  Sub-module: delay_line #(WIDTH, DEPTH), a reset-to-value shift register.
//   Used for {hsync,vsync,blank}, depth 3, reset {SYNC_OFF,SYNC_OFF,1}.
//  Top level holds the position math, the t+1/t+2 registers, the pixel mux and frame_cnt.
// TESTING (bench models buffer RAM and font ROM as 1-cycle synchronous memories)
//  1. Glyph row: mem[0]=0x41, font[0x410]=0x18; drive hc=112..119, vc=145.
//   -> buffer_addr=0, font_addr=0x410; pixel=0,0,0,1,1,0,0,0 three cycles later.
//  2. Corner: hc=623, vc=400 -> buffer_addr=1023, font_addr line=15.
//  3. Inverse: mem[0]=0xC1, same font -> pixel=1,1,1,0,0,1,1,1 for hc 112..119.
//  4. Cursor: cursor_x=5, cursor_y=2, en=1, blank glyph (0x00 rows).
//   -> pixel=1 for hc 152..159, vc 177..192 in frames 0..15; pixel=0 in frames 16..31.
//  5. Blank and sync timing: font rows all 0xFF with hblank=1 -> pixel=0.
//   -> hsync/vsync edges appear on hsync_out/vsync_out exactly 3 cycles later.
//  6. Reset mid-line at hc=300: clr=1.
//   -> same cycle: pixel=0, hsync_out=vsync_out=1, blank_out=1.
//   -> after release: frame_cnt=0 and the cursor is visible.

Source files
------------

// File: rtl/char_renderer_pkg.sv
// Shared constants and helpers for the text-mode character renderer.
package char_renderer_pkg;

  // Screen geometry: first visible pixel and text grid size
  localparam logic [10:0] HBP          = 11'd112;
  localparam logic [10:0] VBP          = 11'd145;
  localparam int          COLS_LOG2    = 6;
  localparam int          ROWS_LOG2    = 4;
  localparam int          GLYPH_W_LOG2 = 3;
  localparam int          GLYPH_H_LOG2 = 4;

  // Cursor blink period is 2^BLINK_LOG2 frames
  localparam int          BLINK_LOG2   = 5;

  // Inactive sync level
  localparam logic        SYNC_OFF     = 1'b1;

  // Sync/blank bundle carried alongside the pixel pipeline
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_RESET = '{hsync: SYNC_OFF, vsync: SYNC_OFF, blank: 1'b1};

  // Select one pixel from a glyph row; bit 7 is the leftmost pixel
  function automatic logic glyph_pixel(input logic [7:0] row_bits,
                                       input logic [GLYPH_W_LOG2-1:0] bit_idx);
    return row_bits[3'd7 - bit_idx];
  endfunction

endpackage

// File: rtl/char_renderer_delay_line.sv
// Reset-to-value shift register used to align sync/blank with the pixel.
module delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the input through DEPTH stages; reset loads every stage with RESET_VAL
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RESET_VAL;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/char_renderer.sv
// Text-mode pixel stage: screen buffer fetch, font fetch, inverse video,
// blinking block cursor. Every output lags hc/vc by exactly 3 clocks.
module char_renderer
  import char_renderer_pkg::*;
(
  input  logic        i_px_clk,
  input  logic        i_clr,
  input  logic [10:0] i_hc,
  input  logic [10:0] i_vc,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_hblank,
  input  logic        i_vblank,
  input  logic [5:0]  i_cursor_x,
  input  logic [3:0]  i_cursor_y,
  input  logic        i_cursor_en,
  output logic [9:0]  o_buffer_addr,
  input  logic [7:0]  i_buffer_data,
  output logic [10:0] o_font_addr,
  input  logic [7:0]  i_font_data,
  output logic        o_pixel,
  output logic        o_hsync_out,
  output logic        o_vsync_out,
  output logic        o_blank_out
);

  // Position inside the display area; only the low bits are meaningful
  logic [8:0]                w_x;
  logic [7:0]                w_y;
  logic [COLS_LOG2-1:0]      w_col;
  logic [GLYPH_W_LOG2-1:0]   w_bit;
  logic [ROWS_LOG2-1:0]      w_row;
  logic [GLYPH_H_LOG2-1:0]   w_line;
  logic                      w_cursor_hit;

  assign w_x    = 9'(i_hc - HBP);
  assign w_y    = 8'(i_vc - VBP);
  assign w_col  = w_x[8:3];
  assign w_bit  = w_x[2:0];
  assign w_row  = w_y[7:4];
  assign w_line = w_y[3:0];

  assign w_cursor_hit  = i_cursor_en && (w_col == i_cursor_x) && (w_row == i_cursor_y);
  assign o_buffer_addr = {w_row, w_col};

  // Stage 1 (buffer data arriving) and stage 2 (font data arriving) state
  logic [GLYPH_H_LOG2-1:0] r_line_d1;
  logic [GLYPH_W_LOG2-1:0] r_bit_d1;
  logic                    r_blank_d1;
  logic                    r_cursor_d1;
  logic [GLYPH_W_LOG2-1:0] r_bit_d2;
  logic                    r_blank_d2;
  logic                    r_cursor_d2;
  logic                    r_inv_d2;
  logic [BLINK_LOG2-1:0]   r_frame_cnt;
  logic                    r_pixel;
  logic                    w_blink_on;
  logic                    w_pixel_next;
  sync_t                   w_sync_in;
  sync_t                   w_sync_d3;

  assign o_font_addr = {i_buffer_data[6:0], r_line_d1};

  // Stage 1: hold pixel position and cursor match while the buffer RAM reads
  always_ff @(posedge i_px_clk or posedge i_clr) begin
    if (i_clr) begin
      r_line_d1   <= 4'd0;
      r_bit_d1    <= 3'd0;
      r_blank_d1  <= 1'b1;
      r_cursor_d1 <= 1'b0;
    end else begin
      r_line_d1   <= w_line;
      r_bit_d1    <= w_bit;
      r_blank_d1  <= i_hblank | i_vblank;
      r_cursor_d1 <= w_cursor_hit;
    end
  end

  // Stage 2: carry position forward and capture the inverse attribute
  always_ff @(posedge i_px_clk or posedge i_clr) begin
    if (i_clr) begin
      r_bit_d2    <= 3'd0;
      r_blank_d2  <= 1'b1;
      r_cursor_d2 <= 1'b0;
      r_inv_d2    <= 1'b0;
    end else begin
      r_bit_d2    <= r_bit_d1;
      r_blank_d2  <= r_blank_d1;
      r_cursor_d2 <= r_cursor_d1;
      r_inv_d2    <= i_buffer_data[7];
    end
  end

  // Frame counter advances once per frame at the (0,0) position
  always_ff @(posedge i_px_clk or posedge i_clr) begin
    if (i_clr) begin
      r_frame_cnt <= '0;
    end else if ((i_hc == 11'd0) && (i_vc == 11'd0)) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end else begin
      r_frame_cnt <= r_frame_cnt;
    end
  end

  // Cursor shows during the first half of each blink period
  assign w_blink_on = ~r_frame_cnt[BLINK_LOG2-1];

  // Pixel mux: glyph bit, then inverse, then cursor; cursor over inverse cancels
  always_comb begin
    w_pixel_next = 1'b0;
    if (r_blank_d2) begin
      w_pixel_next = 1'b0;
    end else begin
      w_pixel_next = glyph_pixel(i_font_data, r_bit_d2) ^ r_inv_d2 ^ (r_cursor_d2 & w_blink_on);
    end
  end

  // Output pixel register
  always_ff @(posedge i_px_clk or posedge i_clr) begin
    if (i_clr) begin
      r_pixel <= 1'b0;
    end else begin
      r_pixel <= w_pixel_next;
    end
  end

  assign w_sync_in = '{hsync: i_hsync, vsync: i_vsync, blank: i_hblank | i_vblank};

  delay_line #(
    .WIDTH     (3),
    .DEPTH     (3),
    .RESET_VAL (SYNC_RESET)
  ) u_sync_delay (
    .i_clk (i_px_clk),
    .i_rst (i_clr),
    .i_d   (w_sync_in),
    .o_q   (w_sync_d3)
  );

  assign o_pixel     = r_pixel;
  assign o_hsync_out = w_sync_d3.hsync;
  assign o_vsync_out = w_sync_d3.vsync;
  assign o_blank_out = w_sync_d3.blank;

endmodule
